// File: rtl/lag_pkg.sv
// Shared types and default widths for the input-lag measurement sequencer.
package lag_pkg;

   localparam int LAG_CNT_W        = 20;
   localparam int LAG_LOG2_SAMPLES = 4;

   // Reset/clear value for the running minimum: any real sample beats it.
   localparam logic [LAG_CNT_W-1:0] MIN_INIT = '1;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_START,
      MEASURE,
      HOLDOFF,
      DONE
   } lag_state_e;

endpackage

// File: rtl/lag_measure_sequencer_if.sv
// Control inputs and result outputs of the lag measurement sequencer.
// master = the side driving run/start_pulse/tick/sensor, slave = the sequencer.
interface lag_measure_sequencer_if
   import lag_pkg::*;
#(
   parameter int CNT_W        = LAG_CNT_W,
   parameter int LOG2_SAMPLES = LAG_LOG2_SAMPLES
);
   logic                    run;
   logic                    start_pulse;
   logic                    tick;
   logic                    sensor;
   logic                    busy;
   logic                    sample_valid;
   logic                    sample_timeout;
   logic [CNT_W-1:0]        sample_ticks;
   logic [LOG2_SAMPLES:0]   sample_count;
   logic [7:0]              timeout_count;
   logic                    stats_valid;
   logic [CNT_W-1:0]        min_ticks;
   logic [CNT_W-1:0]        max_ticks;
   logic [CNT_W-1:0]        avg_ticks;

   modport master (
      output run, start_pulse, tick, sensor,
      input  busy, sample_valid, sample_timeout, sample_ticks, sample_count,
             timeout_count, stats_valid, min_ticks, max_ticks, avg_ticks
   );

   modport slave (
      input  run, start_pulse, tick, sensor,
      output busy, sample_valid, sample_timeout, sample_ticks, sample_count,
             timeout_count, stats_valid, min_ticks, max_ticks, avg_ticks
   );

endinterface

// File: rtl/lag_stats_accum.sv
// Running min/max/sum of accepted lag samples; average latched on request.
module lag_stats_accum
   import lag_pkg::*;
#(
   parameter int CNT_W        = LAG_CNT_W,
   parameter int LOG2_SAMPLES = LAG_LOG2_SAMPLES
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clear,
   input  logic             update,
   input  logic             latch_avg,
   input  logic [CNT_W-1:0] sample,
   output logic [CNT_W-1:0] min_ticks,
   output logic [CNT_W-1:0] max_ticks,
   output logic [CNT_W-1:0] avg_ticks
);

   // Wide enough for 2^LOG2_SAMPLES full-scale samples, so it never wraps.
   localparam int SUM_W = CNT_W + LOG2_SAMPLES;

   logic [CNT_W-1:0] min_q, min_d;
   logic [CNT_W-1:0] max_q, max_d;
   logic [CNT_W-1:0] avg_q, avg_d;
   logic [SUM_W-1:0] sum_q, sum_d;

   // Next-state of the statistics; clear has priority over a sample update.
   always_comb begin
      min_d = min_q;
      max_d = max_q;
      sum_d = sum_q;
      avg_d = avg_q;
      if (clear) begin
         min_d = '1;
         max_d = '0;
         sum_d = '0;
      end else if (update) begin
         if (sample < min_q) min_d = sample;
         if (sample > max_q) max_d = sample;
         sum_d = sum_q + SUM_W'(sample);
      end
      if (latch_avg) avg_d = sum_q[SUM_W-1:LOG2_SAMPLES];
   end

   // Statistics registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         min_q <= '1;
         max_q <= '0;
         sum_q <= '0;
         avg_q <= '0;
      end else begin
         min_q <= min_d;
         max_q <= max_d;
         sum_q <= sum_d;
         avg_q <= avg_d;
      end
   end

   assign min_ticks = min_q;
   assign max_ticks = max_q;
   assign avg_ticks = avg_q;

endmodule

// File: rtl/lag_measure_sequencer.sv
// Input-lag measurement sequencer: arms on frame start, counts ticks until the
// photo sensor rises or the attempt times out, enforces a holdoff, and collects
// 2^LOG2_SAMPLES valid samples into min/max/average statistics.
// Optional build macro: LAG_DEBOUNCE_EN (sensor must stay high DEBOUNCE_CYCLES
// clocks before a rise is accepted).
//
//   state      | meaning
//   -----------+--------------------------------------------------------------
//   IDLE       | not running; results hold their last values
//   WAIT_START | armed, waiting for the frame start pulse
//   MEASURE    | counting ticks until sensor rise or timeout
//   HOLDOFF    | minimum quiet time after an attempt, and sensor must be low
//   DONE       | all samples collected, statistics valid
module lag_measure_sequencer
   import lag_pkg::*;
#(
   parameter int CNT_W           = LAG_CNT_W,
   parameter int LOG2_SAMPLES    = LAG_LOG2_SAMPLES,
   parameter int TIMEOUT_TICKS   = 50000,
   parameter int HOLDOFF_TICKS   = 2000,
   parameter int DEBOUNCE_CYCLES = 64
) (
   input  logic                    clock,
   input  logic                    reset,
   lag_measure_sequencer_if.slave  bus
);

   localparam int HOLD_W = $clog2(HOLDOFF_TICKS + 1);
   localparam logic [LOG2_SAMPLES:0] FULL_COUNT = (LOG2_SAMPLES + 1)'(1 << LOG2_SAMPLES);

   if (TIMEOUT_TICKS < 1 || HOLDOFF_TICKS < 1 || DEBOUNCE_CYCLES < 1) begin : g_param_check
      $error("lag_measure_sequencer: tick/cycle parameters must be at least 1");
   end

   lag_state_e            state_q;
   logic [CNT_W-1:0]      tick_cnt_q;
   logic [HOLD_W-1:0]     hold_cnt_q;
   logic [CNT_W-1:0]      sample_ticks_q;
   logic                  sample_valid_q;
   logic                  sample_timeout_q;
   logic [LOG2_SAMPLES:0] sample_count_q;
   logic [7:0]            timeout_count_q;
   logic                  stats_valid_q;

   logic rise;
   logic hold_exit;
   logic count_full;
   logic stats_clear;
   logic stats_update;
   logic stats_latch_avg;

`ifdef LAG_DEBOUNCE_EN
   localparam int DEB_W = $clog2(DEBOUNCE_CYCLES + 1);

   logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;

   // Consecutive-high counter; saturating so one rise fires per high period.
   always_comb begin
      deb_cnt_d = deb_cnt_q;
      if (!bus.sensor) begin
         deb_cnt_d = '0;
      end else if (deb_cnt_q != DEB_W'(DEBOUNCE_CYCLES)) begin
         deb_cnt_d = deb_cnt_q + DEB_W'(1);
      end
   end

   // Debounce counter register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) deb_cnt_q <= '0;
      else        deb_cnt_q <= deb_cnt_d;
   end

   assign rise = bus.sensor && (deb_cnt_q == DEB_W'(DEBOUNCE_CYCLES - 1));
`else
   logic sensor_q;

   // Previous sensor level for rising-edge detection.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) sensor_q <= 1'b0;
      else        sensor_q <= bus.sensor;
   end

   assign rise = bus.sensor & ~sensor_q;
`endif

   // Transition qualifiers shared by the FSM and the statistics block.
   always_comb begin
      hold_exit       = (hold_cnt_q == '0) && !bus.sensor;
      count_full      = (sample_count_q == FULL_COUNT);
      stats_clear     = bus.run && (state_q == IDLE);
      stats_update    = bus.run && (state_q == MEASURE) && rise;
      stats_latch_avg = bus.run && (state_q == HOLDOFF) && hold_exit && count_full;
   end

   // Sequencer FSM with its tick/holdoff counters and registered outputs.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q          <= IDLE;
         tick_cnt_q       <= '0;
         hold_cnt_q       <= '0;
         sample_ticks_q   <= '0;
         sample_valid_q   <= 1'b0;
         sample_timeout_q <= 1'b0;
         sample_count_q   <= '0;
         timeout_count_q  <= '0;
         stats_valid_q    <= 1'b0;
      end else begin
         sample_valid_q <= 1'b0;
         if (!bus.run) begin
            state_q <= IDLE;
         end else begin
            case (state_q)
               IDLE: begin
                  state_q         <= WAIT_START;
                  sample_count_q  <= '0;
                  timeout_count_q <= '0;
                  stats_valid_q   <= 1'b0;
               end
               WAIT_START: begin
                  if (bus.start_pulse) begin
                     state_q    <= MEASURE;
                     tick_cnt_q <= '0;
                  end
               end
               MEASURE: begin
                  // A rise in the same cycle as a tick reports the pre-tick count.
                  if (rise) begin
                     sample_ticks_q   <= tick_cnt_q;
                     sample_valid_q   <= 1'b1;
                     sample_timeout_q <= 1'b0;
                     sample_count_q   <= sample_count_q + (LOG2_SAMPLES + 1)'(1);
                     hold_cnt_q       <= HOLD_W'(HOLDOFF_TICKS);
                     state_q          <= HOLDOFF;
                  end else if (bus.tick) begin
                     if (tick_cnt_q == CNT_W'(TIMEOUT_TICKS - 1)) begin
                        sample_ticks_q   <= CNT_W'(TIMEOUT_TICKS);
                        sample_valid_q   <= 1'b1;
                        sample_timeout_q <= 1'b1;
                        if (timeout_count_q != 8'hFF) timeout_count_q <= timeout_count_q + 8'd1;
                        hold_cnt_q       <= HOLD_W'(HOLDOFF_TICKS);
                        state_q          <= HOLDOFF;
                     end else begin
                        tick_cnt_q <= tick_cnt_q + CNT_W'(1);
                     end
                  end
               end
               HOLDOFF: begin
                  if (hold_cnt_q == '0) begin
                     if (hold_exit) begin
                        if (count_full) begin
                           state_q       <= DONE;
                           stats_valid_q <= 1'b1;
                        end else begin
                           state_q <= WAIT_START;
                        end
                     end
                  end else if (bus.tick) begin
                     hold_cnt_q <= hold_cnt_q - HOLD_W'(1);
                  end
               end
               DONE: state_q <= DONE;
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   lag_stats_accum #(
      .CNT_W        (CNT_W),
      .LOG2_SAMPLES (LOG2_SAMPLES)
   ) u_stats (
      .clock     (clock),
      .reset     (reset),
      .clear     (stats_clear),
      .update    (stats_update),
      .latch_avg (stats_latch_avg),
      .sample    (tick_cnt_q),
      .min_ticks (bus.min_ticks),
      .max_ticks (bus.max_ticks),
      .avg_ticks (bus.avg_ticks)
   );

   assign bus.busy           = (state_q == WAIT_START) || (state_q == MEASURE) || (state_q == HOLDOFF);
   assign bus.sample_valid   = sample_valid_q;
   assign bus.sample_timeout = sample_timeout_q;
   assign bus.sample_ticks   = sample_ticks_q;
   assign bus.sample_count   = sample_count_q;
   assign bus.timeout_count  = timeout_count_q;
   assign bus.stats_valid    = stats_valid_q;

endmodule

// File: tb/tb_lag_measure_sequencer.sv
// Directed bench for lag_measure_sequencer with small tick/holdoff/timeout values.
module tb_lag_measure_sequencer;

   localparam int CNT_W = 20;
   localparam int L2    = 2;
   localparam int TO    = 100;
   localparam int HO    = 10;
   localparam int DEB   = 8;
   localparam int MIN_ALL = 32'h000F_FFFF;

   logic clock = 1'b0;
   logic reset = 1'b1;

   int checks  = 0;
   int errors  = 0;
   int n_valid = 0;
   int phase   = 0;

   typedef struct {
      int unsigned rise_after;
      int unsigned exp_ticks;
      int unsigned exp_count;
   } samp_t;

   typedef struct {
      int unsigned mn;
      int unsigned mx;
      int unsigned avg;
   } stat_t;

   samp_t tbl[8];
   stat_t st[2];

   lag_measure_sequencer_if #(.CNT_W(CNT_W), .LOG2_SAMPLES(L2)) bus ();

   lag_measure_sequencer #(
      .CNT_W           (CNT_W),
      .LOG2_SAMPLES    (L2),
      .TIMEOUT_TICKS   (TO),
      .HOLDOFF_TICKS   (HO),
      .DEBOUNCE_CYCLES (DEB)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial forever #5 clock = ~clock;

   // One-cycle tick every 4 clocks, changed 1 unit after the rising edge.
   initial begin
      bus.tick = 1'b0;
      forever begin
         @(posedge clock);
         #1;
         phase    = (phase + 1) % 4;
         bus.tick = (phase == 0);
      end
   end

   always @(negedge clock) if (bus.sample_valid === 1'b1) n_valid++;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   // Called 1 unit after a rising edge; start is sampled on the next edge.
   task automatic pulse_start();
      bus.start_pulse = 1'b1;
      @(posedge clock);
      #1;
      bus.start_pulse = 1'b0;
   endtask

   // Start an attempt, let n ticks pass, then raise the sensor between ticks.
   // Returns at the falling edge after the rise has been sampled.
   task automatic do_rise(input int n);
      int cnt;
      pulse_start();
      cnt = 0;
      if (n > 0) begin
         while (cnt < n) begin
            @(posedge clock);
            if (bus.tick) cnt++;
         end
         #1;
      end
      bus.sensor = 1'b1;
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic release_and_wait();
      @(posedge clock);
      #1;
      bus.sensor = 1'b0;
      cycles(60);
   endtask

   task automatic run_table(input int first, input int s);
      for (int i = first; i < first + 4; i++) begin
         do_rise(tbl[i].rise_after);
         chk("samp_valid", bus.sample_valid, 1);
         chk("samp_ticks", bus.sample_ticks, tbl[i].exp_ticks);
         chk("samp_timeout", bus.sample_timeout, 0);
         chk("samp_count", bus.sample_count, tbl[i].exp_count);
         release_and_wait();
      end
      chk("done_stats_valid", bus.stats_valid, 1);
      chk("done_busy", bus.busy, 0);
      chk("done_min", bus.min_ticks, st[s].mn);
      chk("done_max", bus.max_ticks, st[s].mx);
      chk("done_avg", bus.avg_ticks, st[s].avg);
   endtask

   initial begin
      int v0;
      int got;
      int cnt;

      tbl[0] = '{7, 7, 1};
      tbl[1] = '{3, 3, 2};
      tbl[2] = '{12, 12, 3};
      tbl[3] = '{5, 5, 4};
      tbl[4] = '{2, 2, 1};
      tbl[5] = '{2, 2, 2};
      tbl[6] = '{9, 9, 3};
      tbl[7] = '{2, 2, 4};
      st[0]  = '{3, 12, 6};
      st[1]  = '{2, 9, 3};

      bus.run         = 1'b0;
      bus.start_pulse = 1'b0;
      bus.sensor      = 1'b0;

      #2 reset = 1'b0;
      cycles(3);
      chk("rst_busy", bus.busy, 0);
      chk("rst_valid", bus.sample_valid, 0);
      chk("rst_ticks", bus.sample_ticks, 0);
      chk("rst_count", bus.sample_count, 0);
      chk("rst_tcount", bus.timeout_count, 0);
      chk("rst_stats_valid", bus.stats_valid, 0);
      chk("rst_min", bus.min_ticks, MIN_ALL);
      chk("rst_max", bus.max_ticks, 0);
      chk("rst_avg", bus.avg_ticks, 0);
      reset = 1'b1;
      cycles(2);

`ifdef LAG_DEBOUNCE_EN
      bus.run = 1'b1;
      cycles(2);
      pulse_start();
      cycles(2);
      v0 = n_valid;
      bus.sensor = 1'b1;
      cycles(5);
      bus.sensor = 1'b0;
      cycles(20);
      chk("deb_glitch", n_valid - v0, 0);
      bus.sensor = 1'b1;
      repeat (7) @(posedge clock);
      @(negedge clock);
      chk("deb_early", bus.sample_valid, 0);
      @(posedge clock);
      @(negedge clock);
      chk("deb_accept", bus.sample_valid, 1);
      chk("deb_count", bus.sample_count, 1);
`else
      // run=0: start and sensor activity must be ignored
      v0 = n_valid;
      pulse_start();
      bus.sensor = 1'b1;
      cycles(3);
      bus.sensor = 1'b0;
      cycles(2);
      pulse_start();
      cycles(20);
      chk("idle_no_sample", n_valid - v0, 0);
      chk("idle_busy", bus.busy, 0);

      // run A: 7, 3, 12, 5
      bus.run = 1'b1;
      cycles(2);
      chk("run_busy", bus.busy, 1);
      run_table(0, 0);

      // abort from DONE: results held; restart clears
      bus.run = 1'b0;
      cycles(2);
      chk("abort_busy", bus.busy, 0);
      chk("abort_stats_held", bus.stats_valid, 1);
      chk("abort_min_held", bus.min_ticks, 3);
      bus.run = 1'b1;
      cycles(2);
      chk("restart_stats_valid", bus.stats_valid, 0);
      chk("restart_count", bus.sample_count, 0);
      chk("restart_min", bus.min_ticks, MIN_ALL);
      chk("restart_max", bus.max_ticks, 0);

      // timeout with no sensor edge
      pulse_start();
      got = 0;
      for (int i = 0; i < 500 && got == 0; i++) begin
         @(negedge clock);
         if (bus.sample_valid === 1'b1) got = 1;
      end
      chk("to_seen", got, 1);
      chk("to_flag", bus.sample_timeout, 1);
      chk("to_ticks", bus.sample_ticks, TO);
      chk("to_tcount", bus.timeout_count, 1);
      chk("to_count", bus.sample_count, 0);
      @(posedge clock);
      #1;
      cycles(60);
      do_rise(4);
      chk("post_to_valid", bus.sample_valid, 1);
      chk("post_to_ticks", bus.sample_ticks, 4);
      chk("post_to_flag", bus.sample_timeout, 0);
      chk("post_to_count", bus.sample_count, 1);
      chk("post_to_max", bus.max_ticks, 4);

      // holdoff not yet expired: quick re-start must be ignored
      cycles(1);
      bus.sensor = 1'b0;
      cycles(2);
      v0 = n_valid;
      pulse_start();
      bus.sensor = 1'b1;
      cycles(10);
      chk("holdoff_early", n_valid - v0, 0);
      // sensor held past holdoff, start during HOLDOFF ignored
      cycles(60);
      pulse_start();
      cycles(5);
      bus.sensor = 1'b0;
      cycles(3);
      bus.sensor = 1'b1;
      cycles(20);
      chk("holdoff_rearm", n_valid - v0, 0);
      bus.sensor = 1'b0;
      cycles(2);

      // rise and tick in the same cycle at tick_cnt=9
      pulse_start();
      cnt = 0;
      while (cnt < 9) begin
         @(posedge clock);
         if (bus.tick) cnt++;
      end
      repeat (3) @(posedge clock);
      #1;
      bus.sensor = 1'b1;
      @(posedge clock);
      @(negedge clock);
      chk("coll_valid", bus.sample_valid, 1);
      chk("coll_ticks", bus.sample_ticks, 9);
      chk("coll_count", bus.sample_count, 2);
      release_and_wait();

      // abort after two samples, then restart
      bus.run = 1'b0;
      cycles(2);
      chk("abort2_busy", bus.busy, 0);
      chk("abort2_count_held", bus.sample_count, 2);
      chk("abort2_ticks_held", bus.sample_ticks, 9);
      bus.run = 1'b1;
      cycles(2);
      chk("restart2_count", bus.sample_count, 0);
      chk("restart2_tcount", bus.timeout_count, 0);
      chk("restart2_min", bus.min_ticks, MIN_ALL);

      // run B: 2, 2, 9, 2 (ties on min)
      run_table(4, 1);

      // asynchronous reset in the middle of MEASURE
      bus.run = 1'b0;
      cycles(2);
      bus.run = 1'b1;
      cycles(2);
      pulse_start();
      cycles(5);
      #2 reset = 1'b0;
      #1;
      chk("midrst_busy", bus.busy, 0);
      chk("midrst_avg", bus.avg_ticks, 0);
      chk("midrst_ticks", bus.sample_ticks, 0);
      chk("midrst_min", bus.min_ticks, MIN_ALL);
      chk("midrst_valid", bus.sample_valid, 0);
      cycles(2);
      reset = 1'b1;
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
